mdio_master: RTL and testbench
==============================

Name: mdio_master

Overview:
- Clause-22 MDIO management master that configures and monitors the external Ethernet PHY behind the MII PHY interface: link/speed/duplex registers, resets, loopback.
- Accepts single read/write commands over a valid/ready interface and serialises each into an MDC/MDIO frame.
- Returns read data, or a write completion, on a one-cycle response strobe.
- Sits in the system clock domain beside the MAC; MDIO tristate buffer lives at the top level.

Parameters:
MDC_DIV, 10, MDC half-period in clk cycles; legal range >= 2 (elaboration error otherwise)
PREAMBLE_EN, 1, 1 = send 32-bit all-ones preamble (64-bit frame); 0 = preamble suppressed (32-bit frame)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  block idle, command accepted when cmd_valid && cmd_ready
cmd_read  input  1  1 = read, 0 = write
cmd_phy_addr  input  5  PHY address
cmd_reg_addr  input  5  register address
cmd_wdata  input  16  write data (ignored for reads)
rsp_valid  output  1  one-cycle completion strobe
rsp_rdata  output  16  read data, held until next rsp_valid; 0 after a write
rsp_err  output  1  read only: PHY failed to drive TA bit 2 low
busy  output  1  transaction in progress
mdc  output  1  management clock to PHY
mdio_o  output  1  MDIO drive value
mdio_t  output  1  MDIO tristate, 1 = released (high-Z)
mdio_i  input  1  MDIO pad value (externally synchronised)

Behaviour:
- Reset values: cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mdc=0, mdio_o=1, mdio_t=1. Assertion of rst_n mid-frame aborts immediately with all outputs at reset values; no rsp_valid for the aborted command.
- Acceptance: on the accepting edge, latch all cmd_* fields. cmd_ready drops and busy rises in the following cycle. cmd_valid while busy is ignored.
- Frame bits, MSB first:
  - preamble, 32x '1' (only if PREAMBLE_EN)
  - ST = 01
  - OP = 01 (write) or 10 (read)
  - PHYAD[4:0], REGAD[4:0]
  - TA: write = 10; read = released
  - DATA[15:0]
- Bit timing: each bit is a low phase of MDC_DIV clk cycles followed by a high phase of MDC_DIV cycles.
  - mdio_o/mdio_t update on the cycle mdc goes low, i.e. bit start; the first bit starts the cycle after acceptance.
  - mdio_i is sampled on the edge that sets mdc to 1.
- Direction: writes drive mdio_t=0 from the first bit through DATA[0]. Reads drive mdio_t=0 through REGAD[0], then mdio_t=1 for TA and DATA.
- Read capture: DATA is shifted into a 16-bit register from the mdio_i samples. rsp_err = sampled value of the second TA bit (expected 0 when a PHY is present).
- FSM states:
  - IDLE -> PRE (PREAMBLE_EN) or HDR on accept
  - PRE -> HDR after 32 bits
  - HDR (ST, OP, PHYAD, REGAD: 14 bits) -> TA
  - TA (2 bits) -> DATA
  - DATA (16 bits) -> DONE
  - DONE (1 cycle) -> IDLE
  - A 6-bit bit counter and 2-bit state-local counters suffice.
- DONE cycle: mdc=0, mdio_t=1, mdio_o=1, rsp_valid=1, rsp_rdata/rsp_err updated. After a write, rsp_rdata=0 and rsp_err=0. cmd_ready=1 and busy=0 in the same cycle.
- Back-to-back: a command accepted in the DONE cycle starts its first bit on the next cycle. MDC stays low across the gap (at least 1 extra low cycle).
- Latency, accept edge to rsp_valid: FRAME_BITS*2*MDC_DIV + 1 cycles, where FRAME_BITS = 64 or 32.

Decomposition:
- Package mdio_pkg holds:
  - constants MDIO_ST=2'b01, MDIO_OP_WRITE=2'b01, MDIO_OP_READ=2'b10, MDIO_TA_WRITE=2'b10
  - PREAMBLE_BITS=32, HDR_BITS=14, TA_BITS=2, DATA_BITS=16
  - FSM state enum
- One sub-module, mdio_clk_gen:
  - MDC_DIV counter producing mdc plus single-cycle fall_en/rise_en strobes
  - enabled by the FSM, held low and counter cleared when disabled.

Test Plan:
- Write PHY 1 reg 0x00 data 0x1140, MDC_DIV=2, PREAMBLE_EN=1 -> serial capture reads 32x1, 01, 01, 00001, 00000, 10, 0x1140; mdio_t=0 for all 64 bits; rsp_valid at cycle 257 after accept; rsp_rdata=0.
- Read PHY 3 reg 0x01 with PHY model driving TA=Z0 and data 0x796D -> mdio_t=1 from bit 46 on; rsp_rdata=0x796D, rsp_err=0.
- Read with no PHY (mdio_i pulled high) -> rsp_rdata=0xFFFF, rsp_err=1, single rsp_valid pulse.
- PREAMBLE_EN=0, write PHY 0 reg 0x1F data 0xA5A5 -> frame starts with 01, exactly 32 bits; rsp_valid 129 cycles after accept with MDC_DIV=2.
- Back-to-back: cmd_valid held high with write then read queued -> second accepted in first's rsp_valid cycle; no MDC high pulse in gap; cmd_valid pulses while busy have no effect.
- rst_n asserted during DATA bit 5 of a read -> same cycle: mdc=0, mdio_t=1, busy=0, cmd_ready=1; no rsp_valid; a following write completes normally.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared constants and FSM state type for the Clause-22 MDIO master.
package mdio_pkg;

  localparam logic [1:0] MDIO_ST       = 2'b01;
  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;
  localparam logic [1:0] MDIO_TA_WRITE = 2'b10;

  localparam int PREAMBLE_BITS = 32;
  localparam int HDR_BITS      = 14;
  localparam int TA_BITS       = 2;
  localparam int DATA_BITS     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_HDR,
    ST_TA,
    ST_DATA,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: MDC_DIV low cycles then MDC_DIV high cycles per bit, with
// strobes flagging the cycle before each MDC edge.
module mdio_clk_gen #(
  parameter int unsigned MDC_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic mdc_o,
  output logic rise_en_o,
  output logic fall_en_o
);

  localparam int unsigned CW = $clog2(2 * MDC_DIV);
  localparam logic [CW-1:0] RISE_AT = CW'(MDC_DIV - 1);
  localparam logic [CW-1:0] FALL_AT = CW'(2 * MDC_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mdc_q, mdc_d;

  assign rise_en_o = en_i && (cnt_q == RISE_AT);
  assign fall_en_o = en_i && (cnt_q == FALL_AT);
  assign mdc_o     = mdc_q;

  // Disabled means a cleared phase counter, so the next bit starts low.
  always_comb begin
    cnt_d = '0;
    mdc_d = 1'b0;
    if (en_i) begin
      cnt_d = fall_en_o ? '0 : cnt_q + 1'b1;
      if (rise_en_o) begin
        mdc_d = 1'b1;
      end else if (fall_en_o) begin
        mdc_d = 1'b0;
      end else begin
        mdc_d = mdc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: serialises one read/write command into an MDC/MDIO
// frame and returns read data or write completion on a one-cycle strobe.
module mdio_master #(
  parameter int unsigned MDC_DIV     = 10,
  parameter bit          PREAMBLE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_read,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);
  import mdio_pkg::*;

  if (MDC_DIV < 2) begin : g_div_check
    $error("mdio_master: MDC_DIV must be >= 2");
  end

  state_e      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic        rd_q, rd_d;
  logic        ta_err_q, ta_err_d;
  logic        mdio_o_q, mdio_o_d;
  logic        mdio_t_q, mdio_t_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic clk_en, rise_en, fall_en, accept, last_bit;

  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy      = !cmd_ready;
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_t    = mdio_t_q;
  assign accept    = cmd_valid && cmd_ready;
  assign clk_en    = (state_q == ST_PRE) || (state_q == ST_HDR) ||
                     (state_q == ST_TA)  || (state_q == ST_DATA);

  mdio_clk_gen #(.MDC_DIV(MDC_DIV)) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (clk_en),
    .mdc_o     (mdc),
    .rise_en_o (rise_en),
    .fall_en_o (fall_en)
  );

  always_comb begin
    last_bit = 1'b0;
    case (state_q)
      ST_PRE:  last_bit = (bit_cnt_q == 6'(PREAMBLE_BITS - 1));
      ST_HDR:  last_bit = (bit_cnt_q == 6'(HDR_BITS - 1));
      ST_TA:   last_bit = (bit_cnt_q == 6'(TA_BITS - 1));
      ST_DATA: last_bit = (bit_cnt_q == 6'(DATA_BITS - 1));
      default: last_bit = 1'b0;
    endcase
  end

  // Bits after the preamble come from tx_q[31:30]; on a read the TA and DATA
  // slots hold ones so the released line reads as idle in the shift register.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rd_d      = rd_q;
    ta_err_d  = ta_err_q;
    mdio_o_d  = mdio_o_q;
    mdio_t_d  = mdio_t_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d  = ST_IDLE;
        mdio_o_d = 1'b1;
        mdio_t_d = 1'b1;
        if (accept) begin
          state_d   = PREAMBLE_EN ? ST_PRE : ST_HDR;
          bit_cnt_d = '0;
          rd_d      = cmd_read;
          ta_err_d  = 1'b0;
          rx_d      = '0;
          tx_d      = {MDIO_ST, cmd_read ? MDIO_OP_READ : MDIO_OP_WRITE,
                       cmd_phy_addr, cmd_reg_addr,
                       cmd_read ? 2'b11 : MDIO_TA_WRITE,
                       cmd_read ? 16'hFFFF : cmd_wdata};
          mdio_o_d  = PREAMBLE_EN ? 1'b1 : MDIO_ST[1];
          mdio_t_d  = 1'b0;
        end
      end

      ST_PRE: begin
        if (fall_en) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (last_bit) begin
            state_d   = ST_HDR;
            bit_cnt_d = '0;
            mdio_o_d  = tx_q[31];
          end
        end
      end

      default: begin
        if (rise_en) begin
          if (state_q == ST_TA && last_bit) ta_err_d = mdio_i;
          if (state_q == ST_DATA) rx_d = {rx_q[14:0], mdio_i};
        end
        if (fall_en) begin
          tx_d      = {tx_q[30:0], 1'b0};
          mdio_o_d  = tx_q[30];
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (last_bit) begin
            bit_cnt_d = '0;
            case (state_q)
              ST_HDR: begin
                state_d  = ST_TA;
                mdio_t_d = rd_q;
              end
              ST_TA: state_d = ST_DATA;
              default: begin
                state_d  = ST_DONE;
                mdio_o_d = 1'b1;
                mdio_t_d = 1'b1;
                rdata_d  = rd_q ? rx_q : 16'h0000;
                err_d    = rd_q && ta_err_q;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rd_q      <= 1'b0;
      ta_err_q  <= 1'b0;
      mdio_o_q  <= 1'b1;
      mdio_t_q  <= 1'b1;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rd_q      <= rd_d;
      ta_err_q  <= ta_err_d;
      mdio_o_q  <= mdio_o_d;
      mdio_t_q  <= mdio_t_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: instance 0 with preamble, instance 1 without, both
// MDC_DIV=2, checked against a frame-level model and a PHY model.
module tb_mdio_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic        cmd_read  [2];
  logic [4:0]  cmd_phy   [2];
  logic [4:0]  cmd_reg   [2];
  logic [15:0] cmd_wdata [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];
  logic        mdc       [2];
  logic        mdio_o    [2];
  logic        mdio_t    [2];
  logic        mdio_i    [2];

  // Observation state written only by the monitor.
  int          cyc;
  int          bit_idx   [2];
  logic        mdc_prev  [2];
  logic [63:0] cap_o     [2];
  logic [63:0] cap_t     [2];
  logic        cur_rd    [2];
  int          acc_cyc   [2];
  int          rsp_cyc   [2];
  int          rsp_cnt   [2];
  int          done_lat  [2];
  int          done_bits [2];
  logic [63:0] done_o    [2];
  logic [63:0] done_t    [2];
  logic [15:0] done_rdata[2];
  logic        done_err  [2];
  logic [4:0]  done_snap [2];

  // PHY model configuration written only by the stimulus process.
  logic        phy_present [2];
  logic [15:0] phy_data    [2];

  int n_cmp;
  int n_fail;

  mdio_master #(.MDC_DIV(2), .PREAMBLE_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_read(cmd_read[0]),
    .cmd_phy_addr(cmd_phy[0]), .cmd_reg_addr(cmd_reg[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .busy(busy[0]), .mdc(mdc[0]), .mdio_o(mdio_o[0]), .mdio_t(mdio_t[0]),
    .mdio_i(mdio_i[0])
  );

  mdio_master #(.MDC_DIV(2), .PREAMBLE_EN(1'b0)) dut_np (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_read(cmd_read[1]),
    .cmd_phy_addr(cmd_phy[1]), .cmd_reg_addr(cmd_reg[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .busy(busy[1]), .mdc(mdc[1]), .mdio_o(mdio_o[1]), .mdio_t(mdio_t[1]),
    .mdio_i(mdio_i[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole frame, MSB first, left-aligned in 64 bits; released slots read as 1.
  function automatic logic [63:0] exp_frame(input bit pre, input bit rd,
      input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] d);
    logic [31:0] core;
    core = {2'b01, rd ? 2'b10 : 2'b01, phy, rg, rd ? 2'b11 : 2'b10, rd ? 16'hFFFF : d};
    return pre ? {32'hFFFF_FFFF, core} : {core, 32'h0};
  endfunction

  function automatic logic [63:0] rel_mask(input bit pre, input bit rd);
    logic [31:0] core;
    core = rd ? 32'h0003_FFFF : 32'h0;
    return pre ? {32'h0, core} : {core, 32'h0};
  endfunction

  // PHY side: idle line is pulled high; a present PHY answers reads with TA=Z0 then data.
  function automatic logic phy_drive(input int idx, input bit pre, input bit rd,
      input bit present, input logic [15:0] d);
    int base;
    int k;
    base = pre ? 32 : 0;
    if (!rd || !present) return 1'b1;
    if (idx < base + 15) return 1'b1;
    if (idx == base + 15) return 1'b0;
    if (idx < base + 32) begin
      k = 15 - (idx - base - 16);
      return d[k];
    end
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int u = 0; u < 2; u++) begin
      if (mdc[u] === 1'b1 && mdc_prev[u] !== 1'b1) begin
        if (bit_idx[u] < 64) begin
          cap_o[u][63 - bit_idx[u]] = mdio_o[u];
          cap_t[u][63 - bit_idx[u]] = mdio_t[u];
        end
        bit_idx[u] = bit_idx[u] + 1;
      end
      mdc_prev[u] = mdc[u];
      if (rsp_valid[u] === 1'b1) begin
        rsp_cnt[u]    = rsp_cnt[u] + 1;
        rsp_cyc[u]    = cyc;
        done_lat[u]   = cyc - acc_cyc[u];
        done_bits[u]  = bit_idx[u];
        done_o[u]     = cap_o[u];
        done_t[u]     = cap_t[u];
        done_rdata[u] = rsp_rdata[u];
        done_err[u]   = rsp_err[u];
        done_snap[u]  = {mdc[u], mdio_t[u], mdio_o[u], cmd_ready[u], busy[u]};
      end
      if (rst_n === 1'b1 && cmd_valid[u] === 1'b1 && cmd_ready[u] === 1'b1) begin
        acc_cyc[u] = cyc;
        bit_idx[u] = 0;
        cap_o[u]   = '0;
        cap_t[u]   = '0;
        cur_rd[u]  = cmd_read[u];
      end
      mdio_i[u] = phy_drive(bit_idx[u], u == 0, cur_rd[u] === 1'b1,
                            phy_present[u] === 1'b1, phy_data[u]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int u, input bit rd, input logic [4:0] phy,
      input logic [4:0] rg, input logic [15:0] d, output bit ok);
    int n;
    n = 0;
    while (cmd_ready[u] !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    ok = (n < 3000);
    cmd_read[u]  = rd;
    cmd_phy[u]   = phy;
    cmd_reg[u]   = rg;
    cmd_wdata[u] = d;
    cmd_valid[u] = 1'b1;
    tick();
    cmd_valid[u] = 1'b0;
  endtask

  task automatic wait_rsp(input int u, input int start, output bit ok);
    int n;
    n = 0;
    while (rsp_cnt[u] == start && n < 3000) begin
      tick();
      n++;
    end
    ok = (rsp_cnt[u] != start);
  endtask

  task automatic test_reset();
    logic [22:0] obs;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      cmd_valid[u] = 1'b0; cmd_read[u] = 1'b0; cmd_phy[u] = '0; cmd_reg[u] = '0;
      cmd_wdata[u] = '0; phy_present[u] = 1'b0; phy_data[u] = '0;
      bit_idx[u] = 0; rsp_cnt[u] = 0; acc_cyc[u] = 0; cur_rd[u] = 1'b0;
    end
    repeat (3) tick();
    for (int u = 0; u < 2; u++) begin
      obs = {cmd_ready[u], busy[u], rsp_valid[u], rsp_err[u], mdc[u], mdio_o[u],
             mdio_t[u], rsp_rdata[u]};
      n_cmp++;
      if (obs !== {7'b1000011, 16'h0}) begin
        n_fail++;
        $display("[TB] FAIL reset_state u%0d: got %h expected %h", u, obs, {7'b1000011, 16'h0});
      end
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_transaction(input int u, input bit rd, input logic [4:0] phy,
      input logic [4:0] rg, input logic [15:0] d, input bit present, input string tag);
    bit ok;
    bit pre;
    int start, fbits, elat;
    logic [63:0] ef, rm;
    logic [15:0] er;
    logic ee;
    pre   = (u == 0);
    fbits = pre ? 64 : 32;
    elat  = fbits * 2 * 2 + 1;
    ef    = exp_frame(pre, rd, phy, rg, d);
    rm    = rel_mask(pre, rd);
    er    = !rd ? 16'h0000 : (present ? d : 16'hFFFF);
    ee    = rd && !present;
    phy_present[u] = present;
    phy_data[u]    = d;
    start = rsp_cnt[u];
    send(u, rd, phy, rg, d, ok);
    if (ok) wait_rsp(u, start, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL %s/u%0d timeout: got no rsp_valid, expected one", tag, u);
      return;
    end
    repeat (4) tick();
    n_cmp++;
    if ((done_o[u] & ~rm) !== (ef & ~rm)) begin
      n_fail++;
      $display("[TB] FAIL %s/u%0d frame: got %h expected %h", tag, u, done_o[u] & ~rm, ef & ~rm);
    end
    n_cmp++;
    if (done_t[u] !== rm) begin
      n_fail++;
      $display("[TB] FAIL %s/u%0d mdio_t: got %h expected %h", tag, u, done_t[u], rm);
    end
    n_cmp++;
    if (done_bits[u] != fbits) begin
      n_fail++;
      $display("[TB] FAIL %s/u%0d bit_count: got %0d expected %0d", tag, u, done_bits[u], fbits);
    end
    n_cmp++;
    if (done_lat[u] != elat) begin
      n_fail++;
      $display("[TB] FAIL %s/u%0d latency: got %0d expected %0d", tag, u, done_lat[u], elat);
    end
    n_cmp++;
    if ({done_err[u], done_rdata[u]} !== {ee, er}) begin
      n_fail++;
      $display("[TB] FAIL %s/u%0d rsp err/rdata: got %h expected %h", tag, u,
               {done_err[u], done_rdata[u]}, {ee, er});
    end
    n_cmp++;
    if (done_snap[u] !== 5'b01110) begin
      n_fail++;
      $display("[TB] FAIL %s/u%0d done_cycle mdc/t/o/ready/busy: got %b expected 01110",
               tag, u, done_snap[u]);
    end
    n_cmp++;
    if (rsp_cnt[u] != start + 1) begin
      n_fail++;
      $display("[TB] FAIL %s/u%0d rsp_pulses: got %0d expected 1", tag, u, rsp_cnt[u] - start);
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    for (int i = 0; i < 4; i++) begin
      for (int u = 0; u < 2; u++) begin
        d = 16'($urandom);
        test_transaction(u, 1'($urandom), 5'($urandom), 5'($urandom), d,
                         1'($urandom), "random");
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int start, first_rsp;
    logic [15:0] wd, rdd;
    logic [4:0] rphy, rreg;
    wd = 16'($urandom); rdd = 16'($urandom);
    rphy = 5'($urandom); rreg = 5'($urandom);
    start = rsp_cnt[0];
    phy_present[0] = 1'b1;
    phy_data[0]    = rdd;
    cmd_read[0] = 1'b0; cmd_phy[0] = 5'd2; cmd_reg[0] = 5'd4; cmd_wdata[0] = wd;
    cmd_valid[0] = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      cmd_valid[0] = i[0];
      cmd_read[0]  = 1'($urandom);
      cmd_phy[0]   = 5'($urandom);
      cmd_reg[0]   = 5'($urandom);
      cmd_wdata[0] = 16'($urandom);
      tick();
    end
    cmd_read[0] = 1'b1; cmd_phy[0] = rphy; cmd_reg[0] = rreg; cmd_wdata[0] = 16'h0;
    cmd_valid[0] = 1'b1;
    wait_rsp(0, start, ok);
    cmd_valid[0] = 1'b0;
    first_rsp = rsp_cyc[0];
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL b2b first timeout: got no rsp_valid, expected one");
      return;
    end
    n_cmp++;
    if ((done_o[0] !== exp_frame(1'b1, 1'b0, 5'd2, 5'd4, wd)) || done_bits[0] != 64) begin
      n_fail++;
      $display("[TB] FAIL b2b first frame: got %h/%0d expected %h/64", done_o[0], done_bits[0],
               exp_frame(1'b1, 1'b0, 5'd2, 5'd4, wd));
    end
    n_cmp++;
    if (acc_cyc[0] != first_rsp) begin
      n_fail++;
      $display("[TB] FAIL b2b accept_cycle: got %0d expected %0d", acc_cyc[0], first_rsp);
    end
    wait_rsp(0, start + 1, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL b2b second timeout: got no rsp_valid, expected one");
      return;
    end
    n_cmp++;
    if (((done_o[0] & ~rel_mask(1'b1, 1'b1)) !== (exp_frame(1'b1, 1'b1, rphy, rreg, 16'h0) &
         ~rel_mask(1'b1, 1'b1))) || done_bits[0] != 64) begin
      n_fail++;
      $display("[TB] FAIL b2b second frame: got %h/%0d expected header of %h/64", done_o[0],
               done_bits[0], exp_frame(1'b1, 1'b1, rphy, rreg, 16'h0));
    end
    n_cmp++;
    if ({done_err[0], done_rdata[0]} !== {1'b0, rdd} || done_lat[0] != 257) begin
      n_fail++;
      $display("[TB] FAIL b2b second rsp: got %h lat %0d expected %h lat 257",
               {done_err[0], done_rdata[0]}, done_lat[0], {1'b0, rdd});
    end
    repeat (3) tick();
  endtask

  task automatic test_abort();
    bit ok;
    int start, n;
    logic [4:0] obs;
    start = rsp_cnt[0];
    phy_present[0] = 1'b1;
    phy_data[0]    = 16'($urandom);
    send(0, 1'b1, 5'd5, 5'd1, 16'h0, ok);
    n = 0;
    while (bit_idx[0] != 53 && n < 3000) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n >= 3000) begin
      n_fail++;
      $display("[TB] FAIL abort reach_data_bit5: got bit %0d expected 53", bit_idx[0]);
    end
    tick();
    rst_n = 1'b0;
    #1;
    obs = {mdc[0], mdio_t[0], busy[0], cmd_ready[0], rsp_valid[0]};
    n_cmp++;
    if (obs !== 5'b01010) begin
      n_fail++;
      $display("[TB] FAIL abort outputs mdc/t/busy/ready/rsp: got %b expected 01010", obs);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (300) tick();
    n_cmp++;
    if (rsp_cnt[0] != start) begin
      n_fail++;
      $display("[TB] FAIL abort no_rsp: got %0d pulses expected 0", rsp_cnt[0] - start);
    end
    test_transaction(0, 1'b0, 5'd7, 5'd9, 16'($urandom), 1'b0, "after_abort");
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    test_reset();
    test_transaction(0, 1'b0, 5'd1, 5'h00, 16'h1140, 1'b0, "write_pre");
    test_transaction(0, 1'b1, 5'd3, 5'h01, 16'h796D, 1'b1, "read_pre");
    test_transaction(0, 1'b1, 5'd9, 5'h02, 16'h1234, 1'b0, "read_nophy");
    test_transaction(1, 1'b0, 5'd0, 5'h1F, 16'hA5A5, 1'b0, "write_nopre");
    test_transaction(1, 1'b1, 5'd3, 5'h01, 16'h796D, 1'b1, "read_nopre");
    test_random();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
